ffs_rr_arbiter: RTL and testbench

//   Round-robin arbiter sharing one resource among up to 32 requesters.

---
 rtl/ffs_rr_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_ffs_rr_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ffs_rr_arbiter.sv
// ffs_rr_arbiter: round-robin arbiter that shares one resource among up to 32 requesters.
//
// Priority selection uses two find_first_set32 instances. One scans the request vector
// masked below the rotating pointer. The other scans the unmasked vector, and it is used
// when the masked vector is empty. The grant is registered. It is held while the owner
// keeps requesting, and an optional hold timeout forces rotation.
//
// Parameters: N (1..32), HOLD_MAX (0 = no timeout), FFS_IMPL ("LOW" | "HIGH").
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   req[N-1:0]   in   level-sensitive requests
//   grant[N-1:0] out  registered one-hot grant
//   grant_valid  out  any grant bit set
//   grant_idx    out  current owner index (holds the last owner while idle)
//   grant_count  out  (only with ARB_GRANT_COUNT_EN) number of grants issued, wraps at 2^32
//
// Optional feature macro: ARB_GRANT_COUNT_EN

// find_first_set32: returns the index of the lowest set bit of vec.
// "LOW" uses a priority scan and "HIGH" uses a binary halving tree. Both give the same
// result. The index is 0 when vec is empty.
module find_first_set32 #(
  parameter string IMPLEMENTATION = "LOW"
) (
  input  logic [31:0] vec,
  output logic [4:0]  idx,
  output logic        found
);
  assign found = |vec;

  generate
    if (IMPLEMENTATION == "HIGH") begin : g_tree
      logic        b4, b3, b2, b1, b0;
      logic [15:0] v16;
      logic [7:0]  v8;
      logic [3:0]  v4;
      logic [1:0]  v2;
      always_comb begin
        b4  = ~|vec[15:0];
        v16 = b4 ? vec[31:16] : vec[15:0];
        b3  = ~|v16[7:0];
        v8  = b3 ? v16[15:8] : v16[7:0];
        b2  = ~|v8[3:0];
        v4  = b2 ? v8[7:4] : v8[3:0];
        b1  = ~|v4[1:0];
        v2  = b1 ? v4[3:2] : v4[1:0];
        b0  = ~v2[0];
        idx = found ? {b4, b3, b2, b1, b0} : 5'd0;
      end
    end else begin : g_scan
      always_comb begin
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
          if (vec[i]) idx = 5'(i);
        end
      end
    end
  endgenerate
endmodule

// State table:
//   IDLE | no grant outstanding; the next request is picked from ptr
//   BUSY | grant held by owner grant_idx; released on drop or hold timeout
module ffs_rr_arbiter #(
  parameter int    N        = 32,
  parameter int    HOLD_MAX = 16,
  parameter string FFS_IMPL = "LOW"
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         grant_valid,
`ifdef ARB_GRANT_COUNT_EN
  output logic [31:0]  grant_count,
`endif
  output logic [4:0]   grant_idx
);
  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] grant_q, grant_d;
  logic [4:0]   idx_q, idx_d;
  logic [4:0]   ptr_q, ptr_d;
  logic [31:0]  hold_cnt_q, hold_cnt_d;
  logic         new_grant;

  logic [31:0]  req32, masked;
  logic [4:0]   owner_nxt, pick_ptr, m_idx, u_idx, pick_idx;
  logic         m_found, u_found, owner_req, hold_hit;

  always_comb begin
    req32 = '0;
    req32[N-1:0] = req;
  end

  assign owner_nxt = (idx_q == 5'(N - 1)) ? 5'd0 : idx_q + 5'd1;
  // On a handover the new pick starts just past the outgoing owner, in the same edge.
  assign pick_ptr  = (state_q == BUSY) ? owner_nxt : ptr_q;
  assign masked    = req32 & (32'hFFFF_FFFF << pick_ptr);

  find_first_set32 #(.IMPLEMENTATION(FFS_IMPL)) u_ffs_masked (
    .vec(masked), .idx(m_idx), .found(m_found)
  );
  find_first_set32 #(.IMPLEMENTATION(FFS_IMPL)) u_ffs_unmasked (
    .vec(req32), .idx(u_idx), .found(u_found)
  );

  assign pick_idx  = m_found ? m_idx : u_idx;
  assign owner_req = req32[idx_q];
  assign hold_hit  = (HOLD_MAX != 0) && (hold_cnt_q == 32'(HOLD_MAX));

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    new_grant  = 1'b0;
    case (state_q)
      IDLE: begin
        if (u_found) new_grant = 1'b1;
      end
      BUSY: begin
        if (!owner_req || hold_hit) begin
          ptr_d = owner_nxt;
          if (u_found) begin
            new_grant = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (hold_cnt_q != 32'hFFFF_FFFF) begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    if (new_grant) begin
      state_d    = BUSY;
      grant_d    = N'(32'd1 << pick_idx);
      idx_d      = pick_idx;
      hold_cnt_d = 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      idx_q      <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_idx   = idx_q;

`ifdef ARB_GRANT_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (new_grant) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign grant_count = cnt_q;
`endif
endmodule

// File: tb/tb_ffs_rr_arbiter.sv
// tb_ffs_rr_arbiter: directed and randomized checks of ffs_rr_arbiter.
// Three instances share clk/rst/req:
//   dut0:  HOLD_MAX=0, FFS_IMPL "LOW"
//   dut4:  HOLD_MAX=4, FFS_IMPL "LOW"
//   dut4h: HOLD_MAX=4, FFS_IMPL "HIGH"
module tb_ffs_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] req = '0;

  logic [31:0] g0, g4, g4h;
  logic        v0, v4, v4h;
  logic [4:0]  i0, i4, i4h;
`ifdef ARB_GRANT_COUNT_EN
  logic [31:0] c0, c4, c4h;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ffs_rr_arbiter #(.N(32), .HOLD_MAX(0), .FFS_IMPL("LOW")) dut0 (
    .clk(clk), .rst(rst), .req(req), .grant(g0), .grant_valid(v0),
`ifdef ARB_GRANT_COUNT_EN
    .grant_count(c0),
`endif
    .grant_idx(i0)
  );
  ffs_rr_arbiter #(.N(32), .HOLD_MAX(4), .FFS_IMPL("LOW")) dut4 (
    .clk(clk), .rst(rst), .req(req), .grant(g4), .grant_valid(v4),
`ifdef ARB_GRANT_COUNT_EN
    .grant_count(c4),
`endif
    .grant_idx(i4)
  );
  ffs_rr_arbiter #(.N(32), .HOLD_MAX(4), .FFS_IMPL("HIGH")) dut4h (
    .clk(clk), .rst(rst), .req(req), .grant(g4h), .grant_valid(v4h),
`ifdef ARB_GRANT_COUNT_EN
    .grant_count(c4h),
`endif
    .grant_idx(i4h)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference model for the HOLD_MAX=4 instances.
  logic        m_valid;
  logic [4:0]  m_idx, m_ptr;
  int          m_hold;
  logic [31:0] m_cnt;
  logic        m_new;
  int          wait_cnt [32];
  int          max_wait;

  function automatic logic [4:0] mpick(input logic [31:0] r, input logic [4:0] p);
    for (int k = 0; k < 32; k++) begin
      int j;
      j = (int'(p) + k) % 32;
      if (r[j]) return 5'(j);
    end
    return 5'd0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_idx = '0; m_ptr = '0; m_hold = 0; m_cnt = '0; m_new = 1'b0;
    max_wait = 0;
    for (int i = 0; i < 32; i++) wait_cnt[i] = 0;
  endtask

  task automatic model_step(input logic [31:0] r);
    m_new = 1'b0;
    if (!m_valid) begin
      if (r != 0) begin
        m_idx = mpick(r, m_ptr); m_valid = 1'b1; m_hold = 1; m_new = 1'b1;
      end
    end else if (!r[m_idx] || m_hold == 4) begin
      m_ptr = (m_idx == 5'd31) ? 5'd0 : m_idx + 5'd1;
      if (r != 0) begin
        m_idx = mpick(r, m_ptr); m_hold = 1; m_new = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end else begin
      m_hold++;
    end
    if (m_new) m_cnt = m_cnt + 32'd1;
    for (int i = 0; i < 32; i++) begin
      if (!r[i] || (m_valid && m_idx == 5'(i))) wait_cnt[i] = 0;
      else if (m_new) wait_cnt[i]++;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
  endtask

  logic [31:0] exp_g;
  logic [31:0] r;
  int          hold_left;

  initial begin
    // Reset and then idle requests.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      check("idle_grant", g0, 32'h0);
      check("idle_valid", 32'(v0), 32'h0);
      check("idle_idx", 32'(i0), 32'h0);
    end

    // Hold with no timeout, then handover on the same edge, then back to idle.
    req = 32'h0000_0090;
    tick();
    check("hold0_first", g0, 32'h0000_0010);
    check("hold0_idx", 32'(i0), 32'd4);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("hold0_keep", g0, 32'h0000_0010);
    end
    req = 32'h0000_0080;
    tick();
    check("handover_grant", g0, 32'h0000_0080);
    check("handover_idx", 32'(i0), 32'd7);
    req = 32'h0;
    tick();
    check("release_grant", g0, 32'h0);
    check("release_valid", 32'(v0), 32'h0);
    check("release_idx_held", 32'(i0), 32'd7);

    // Timeout rotation between idx 0 and idx 31, including the pointer wrap.
    do_reset();
    req = 32'h8000_0001;
    for (int c = 0; c < 16; c++) begin
      tick();
      exp_g = ((c / 4) % 2 == 0) ? 32'h0000_0001 : 32'h8000_0000;
      check("rot_grant", g4, exp_g);
      check("rot_grant_high", g4h, exp_g);
      check("rot_idx", 32'(i4), ((c / 4) % 2 == 0) ? 32'd0 : 32'd31);
      check("rot_notimeout", g0, 32'h0000_0001);
    end

    // A sole requester that times out is re-granted without a gap.
    do_reset();
    req = 32'h0000_0020;
    for (int c = 0; c < 12; c++) begin
      tick();
      check("regrant_grant", g4, 32'h0000_0020);
      check("regrant_valid", 32'(v4), 32'h1);
`ifdef ARB_GRANT_COUNT_EN
      check("regrant_count", c4, 32'(c / 4 + 1));
      check("regrant_count0", c0, 32'd1);
`endif
    end

    // Asynchronous reset in the middle of a grant.
    do_reset();
    req = 32'h0000_0300;
    tick();
    check("rst_first_idx", 32'(i0), 32'd8);
    req = 32'h0000_0200;
    tick();
    check("rst_pre_idx", 32'(i0), 32'd9);
    req = 32'h0000_0300;
    tick();
    check("rst_pre_grant", g0, 32'h0000_0200);
    #2 rst = 1'b1;
    #1;
    check("rst_async_grant", g0, 32'h0);
    check("rst_async_valid", 32'(v0), 32'h0);
    #2 rst = 1'b0;
    tick();
    check("rst_after_grant", g0, 32'h0000_0100);
    check("rst_after_idx", 32'(i0), 32'd8);

    // Randomized requests, held for a few cycles each.
    do_reset();
    model_reset();
    hold_left = 0;
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_left == 0) begin
        r = $urandom & $urandom;
        if ($urandom_range(0, 7) == 0) r = '0;
        hold_left = $urandom_range(1, 6);
      end
      hold_left--;
      req = r;
      tick();
      model_step(r);
      exp_g = m_valid ? (32'd1 << m_idx) : 32'h0;
      check("rnd_grant", g4, exp_g);
      check("rnd_impl_match", g4h, g4);
      check("rnd_idx_match", 32'(i4h), 32'(i4));
      if (m_valid) check("rnd_idx", 32'(i4), 32'(m_idx));
      check("rnd_valid", 32'(v4), 32'(m_valid));
      check("rnd_onehot0", 32'($onehot0(g0)), 32'h1);
      check("rnd_valid0", 32'(v0), 32'(g0 != 0));
      if (v0) check("rnd_idx0", 32'd1 << i0, g0);
`ifdef ARB_GRANT_COUNT_EN
      check("rnd_count", c4, m_cnt);
      check("rnd_count_high", c4h, m_cnt);
`endif
    end
    check("rnd_max_wait", 32'(max_wait <= 31), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
